// File: rtl/vga_code_scheduler.sv
// vga_code_scheduler
// Round-robin arbiter that shares the 24-bit colour-code input of the VGA
// output stage among N_REQ requesters. A free-running frame counter, reset
// together with the VGA stage, marks the frame boundary where the VGA stage
// latches the code. The winner receives a done pulse once its code has been
// latched. Optionally, a committed code is held for HOLD_FRAMES more frames.
module vga_code_scheduler #(
    parameter int N_REQ       = 2,
    parameter int H_TOTAL     = 1040,
    parameter int V_TOTAL     = 666,
    parameter int HOLD_FRAMES = 0,
    localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [24*N_REQ-1:0]   req_code,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      done,
    output logic [23:0]           code,
    output logic [ID_W-1:0]       grant_id,
    output logic                  busy,
    output logic                  frame_tick
);

    localparam int FRAME_LEN = H_TOTAL * V_TOTAL;
    localparam int FCNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);
    localparam int HCNT_W    = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [HCNT_W-1:0] HCNT_LOAD = HCNT_W'(HOLD_FRAMES);
    localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);
    localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [FCNT_W-1:0]     fcnt_r;
    logic [FCNT_W-1:0]     fcnt_next_s;
    logic                  frame_tick_r;
    logic [HCNT_W-1:0]     hcnt_r;
    logic [ID_W-1:0]       rr_ptr_r;
    logic [ID_W-1:0]       rr_ptr_next_s;
    logic [ID_W-1:0]       grant_id_r;
    logic [23:0]           code_r;
    logic [N_REQ-1:0]      done_r;
    logic                  busy_r;

    logic                  win_found_s;
    logic [ID_W-1:0]       win_idx_s;
    logic [23:0]           win_code_s;
    logic                  grant_open_s;
    logic                  handshake_s;
    logic [N_REQ-1:0]      ready_s;
    logic [N_REQ-1:0]      done_set_s;
    logic                  hold_last_s;

    // Next value of the frame counter, wrapping at the end of the frame.
    always_comb begin
        if (fcnt_r == FCNT_LAST) begin
            fcnt_next_s = '0;
        end else begin
            fcnt_next_s = fcnt_r + FCNT_W'(1);
        end
    end

    // Frame counter and its registered last-cycle flag, in lock-step with the VGA stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_r       <= '0;
            frame_tick_r <= (FCNT_LAST == '0);
        end else begin
            fcnt_r       <= fcnt_next_s;
            frame_tick_r <= (fcnt_next_s == FCNT_LAST);
        end
    end

    // Round-robin search: first valid requester at or above rr_ptr, then wrap to the bottom.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found_s && req_valid[i] && (ID_W'(i) >= rr_ptr_r)) begin
                win_found_s = 1'b1;
                win_idx_s   = ID_W'(i);
            end else begin
                win_found_s = win_found_s;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found_s && req_valid[i] && (ID_W'(i) < rr_ptr_r)) begin
                win_found_s = 1'b1;
                win_idx_s   = ID_W'(i);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Code multiplexer for the current winner and the pointer value that follows it.
    always_comb begin
        win_code_s = 24'h000000;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == win_idx_s) begin
                win_code_s = req_code[24*i +: 24];
            end else begin
                win_code_s = win_code_s;
            end
        end
        if (win_idx_s == ID_LAST) begin
            rr_ptr_next_s = '0;
        end else begin
            rr_ptr_next_s = win_idx_s + ID_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: grant, wait for the VGA latch edge, then optionally hold.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (handshake_s) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (frame_tick_r) begin
                    state_next_s = (HOLD_FRAMES == 0) ? ST_IDLE : ST_HOLD;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (hold_last_s) begin
                    state_next_s = handshake_s ? ST_WAIT : ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: the grant window, one-hot ready, handshake and done request.
    always_comb begin
        hold_last_s  = (state_r == ST_HOLD) && frame_tick_r && (hcnt_r == HCNT_ONE);
        // The final hold-frame tick may grant: the new code changes on the same
        // edge the VGA stage latches the old one, so it commits one frame later.
        grant_open_s = (state_r == ST_IDLE) || hold_last_s;
        handshake_s  = grant_open_s && win_found_s;
        ready_s      = '0;
        done_set_s   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (handshake_s && (ID_W'(i) == win_idx_s)) begin
                ready_s[i] = 1'b1;
            end else begin
                ready_s[i] = 1'b0;
            end
            if ((state_r == ST_WAIT) && frame_tick_r && (ID_W'(i) == grant_id_r)) begin
                done_set_s[i] = 1'b1;
            end else begin
                done_set_s[i] = 1'b0;
            end
        end
    end

    // Captured code, winner id and round-robin pointer; updated only on a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_r     <= 24'h000000;
            grant_id_r <= '0;
            rr_ptr_r   <= '0;
        end else if (handshake_s) begin
            code_r     <= win_code_s;
            grant_id_r <= win_idx_s;
            rr_ptr_r   <= rr_ptr_next_s;
        end else begin
            code_r     <= code_r;
            grant_id_r <= grant_id_r;
            rr_ptr_r   <= rr_ptr_r;
        end
    end

    // Hold-frame counter: loaded when a code commits, counted down on each frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_r <= '0;
        end else if ((state_r == ST_WAIT) && frame_tick_r) begin
            hcnt_r <= HCNT_LOAD;
        end else if ((state_r == ST_HOLD) && frame_tick_r && (hcnt_r != '0)) begin
            hcnt_r <= hcnt_r - HCNT_W'(1);
        end else begin
            hcnt_r <= hcnt_r;
        end
    end

    // Registered done pulse and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r <= '0;
            busy_r <= 1'b0;
        end else begin
            done_r <= done_set_s;
            busy_r <= (state_next_s != ST_IDLE);
        end
    end

    assign req_ready  = rst_n ? ready_s : '0;
    assign done       = done_r;
    assign code       = code_r;
    assign grant_id   = grant_id_r;
    assign busy       = busy_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_vga_code_scheduler.sv
// Testbench for vga_code_scheduler on a 32-cycle frame (H_TOTAL=8, V_TOTAL=4).
// Instance dut uses HOLD_FRAMES=0, dut_h uses HOLD_FRAMES=2. Cycle c is the
// clock period in which the frame counter holds c (cycle 0 follows reset release).
module tb_vga_code_scheduler;

    typedef struct {
        logic [23:0] code;
        int          id;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic [1:0]  valid_a, ready_a, done_a;
    logic [47:0] rcode_a;
    logic [23:0] code_a;
    logic [0:0]  gid_a;
    logic        busy_a, tick_a;

    logic [1:0]  valid_h, ready_h, done_h;
    logic [47:0] rcode_h;
    logic [23:0] code_h;
    logic [0:0]  gid_h;
    logic        busy_h, tick_h;

    exp_t sb_a[$];
    exp_t sb_h[$];

    always #5 clk = ~clk;

    vga_code_scheduler #(.N_REQ(2), .H_TOTAL(8), .V_TOTAL(4), .HOLD_FRAMES(0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_code(rcode_a),
        .req_ready(ready_a), .done(done_a), .code(code_a), .grant_id(gid_a),
        .busy(busy_a), .frame_tick(tick_a)
    );

    vga_code_scheduler #(.N_REQ(2), .H_TOTAL(8), .V_TOTAL(4), .HOLD_FRAMES(2)) dut_h (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_h), .req_code(rcode_h),
        .req_ready(ready_h), .done(done_h), .code(code_h), .grant_id(gid_h),
        .busy(busy_h), .frame_tick(tick_h)
    );

    // Scoreboard for dut: every done pulse must match the oldest expected commit.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb_a.delete();
        end else if (done_a !== 2'b00) begin
            checks++;
            if (sb_a.size() == 0) begin
                failures++;
                $display("FAIL sb_a_unexpected_done cyc=%0d done=%b expected no pulse", cyc, done_a);
            end else begin
                e = sb_a.pop_front();
                if (done_a !== (2'b01 << e.id) || cyc != e.cyc || code_a !== e.code) begin
                    failures++;
                    $display("FAIL sb_a_done got done=%b cyc=%0d code=%h expected done=%b cyc=%0d code=%h",
                             done_a, cyc, code_a, 2'b01 << e.id, e.cyc, e.code);
                end
            end
        end else if (sb_a.size() != 0 && sb_a[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL sb_a_missing_done at cyc=%0d expected done for id %0d at cyc=%0d", cyc, sb_a[0].id, sb_a[0].cyc);
            void'(sb_a.pop_front());
        end
    end

    // Scoreboard for dut_h (hold-frame instance).
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb_h.delete();
        end else if (done_h !== 2'b00) begin
            checks++;
            if (sb_h.size() == 0) begin
                failures++;
                $display("FAIL sb_h_unexpected_done cyc=%0d done=%b expected no pulse", cyc, done_h);
            end else begin
                e = sb_h.pop_front();
                if (done_h !== (2'b01 << e.id) || cyc != e.cyc || code_h !== e.code) begin
                    failures++;
                    $display("FAIL sb_h_done got done=%b cyc=%0d code=%h expected done=%b cyc=%0d code=%h",
                             done_h, cyc, code_h, 2'b01 << e.id, e.cyc, e.code);
                end
            end
        end else if (sb_h.size() != 0 && sb_h[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL sb_h_missing_done at cyc=%0d expected done for id %0d at cyc=%0d", cyc, sb_h[0].id, sb_h[0].cyc);
            void'(sb_h.pop_front());
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        valid_a = 2'b00;
        valid_h = 2'b00;
        rcode_a = 48'h0;
        rcode_h = 48'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        valid_a = 2'b11;
        rcode_a = {24'h222222, 24'h111111};
        #2;
        checks++;
        if (ready_a !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready got %b expected 00", ready_a);
        end
        do_reset();
        for (int c = 0; c <= 96; c++) begin
            if (c > 0) next_cycle();
            #2;
            checks++;
            if (code_a !== 24'h0 || done_a !== 2'b00 || busy_a !== 1'b0 || gid_a !== 1'b0) begin
                failures++;
                $display("FAIL idle_state c=%0d got code=%h done=%b busy=%b gid=%b expected 0", c, code_a, done_a, busy_a, gid_a);
            end
            checks++;
            if (tick_a !== (c % 32 == 31)) begin
                failures++;
                $display("FAIL frame_tick c=%0d got %b expected %b", c, tick_a, (c % 32 == 31));
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) next_cycle();
            if (c == 5) begin
                valid_a = 2'b01;
                rcode_a = {24'h0DEAD0, 24'hF00ABC};
                sb_a.push_back('{code: 24'hF00ABC, id: 0, cyc: 32});
            end else if (c == 6) begin
                valid_a = 2'b00;
                rcode_a = {24'h0DEAD0, 24'h123456};
            end
            #2;
            if (c == 4 || c == 5) begin
                checks++;
                if (ready_a !== ((c == 5) ? 2'b01 : 2'b00)) begin
                    failures++;
                    $display("FAIL single_ready c=%0d got %b expected %b", c, ready_a, (c == 5) ? 2'b01 : 2'b00);
                end
            end
            if (c >= 6) begin
                checks++;
                if (code_a !== 24'hF00ABC) begin
                    failures++;
                    $display("FAIL single_code c=%0d got %h expected F00ABC", c, code_a);
                end
            end
            if (c >= 5 && c <= 33) begin
                checks++;
                if (busy_a !== (c >= 6 && c <= 31)) begin
                    failures++;
                    $display("FAIL single_busy c=%0d got %b expected %b", c, busy_a, (c >= 6 && c <= 31));
                end
            end
        end
        checks++;
        if (sb_a.size() != 0) begin
            failures++;
            $display("FAIL single_drain got %0d pending expected 0", sb_a.size());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        valid_a = 2'b11;
        rcode_a = {24'h222222, 24'h111111};
        for (int k = 0; k < 4; k++) begin
            sb_a.push_back('{code: (k % 2 == 0) ? 24'h111111 : 24'h222222, id: k % 2, cyc: 32 * (k + 1)});
        end
        for (int c = 0; c <= 130; c++) begin
            if (c > 0) next_cycle();
            if (c == 97) valid_a = 2'b00;
            #2;
            if (c == 0 || c == 32 || c == 64 || c == 96) begin
                checks++;
                if (ready_a !== (2'b01 << ((c / 32) % 2))) begin
                    failures++;
                    $display("FAIL rr_ready c=%0d got %b expected %b", c, ready_a, 2'b01 << ((c / 32) % 2));
                end
            end
            if (c == 1 || c == 33 || c == 65 || c == 97) begin
                checks++;
                if (gid_a !== 1'(((c - 1) / 32) % 2) || code_a !== ((((c - 1) / 32) % 2 == 0) ? 24'h111111 : 24'h222222)) begin
                    failures++;
                    $display("FAIL rr_grant c=%0d got gid=%b code=%h expected gid=%0d", c, gid_a, code_a, ((c - 1) / 32) % 2);
                end
            end
        end
        checks++;
        if (sb_a.size() != 0) begin
            failures++;
            $display("FAIL rr_drain got %0d pending expected 0", sb_a.size());
        end
    endtask

    task automatic test_tick_accept();
        do_reset();
        for (int c = 0; c <= 66; c++) begin
            if (c > 0) next_cycle();
            if (c == 31) begin
                valid_a = 2'b01;
                rcode_a = {24'h000000, 24'hC0FFEE};
                sb_a.push_back('{code: 24'hC0FFEE, id: 0, cyc: 64});
            end else if (c == 32) begin
                valid_a = 2'b00;
            end
            #2;
            if (c == 31) begin
                checks++;
                if (ready_a !== 2'b01 || code_a !== 24'h0) begin
                    failures++;
                    $display("FAIL tick_accept_ready got ready=%b code=%h expected 01 000000", ready_a, code_a);
                end
            end
            if (c == 32) begin
                checks++;
                if (code_a !== 24'hC0FFEE || busy_a !== 1'b1) begin
                    failures++;
                    $display("FAIL tick_accept_code got code=%h busy=%b expected C0FFEE 1", code_a, busy_a);
                end
            end
        end
        checks++;
        if (sb_a.size() != 0) begin
            failures++;
            $display("FAIL tick_accept_drain got %0d pending expected 0", sb_a.size());
        end
    endtask

    task automatic test_hold_frames();
        do_reset();
        valid_h = 2'b01;
        rcode_h = {24'h000000, 24'hABCDEF};
        sb_h.push_back('{code: 24'hABCDEF, id: 0, cyc: 32});
        sb_h.push_back('{code: 24'h13579B, id: 0, cyc: 128});
        for (int c = 0; c <= 130; c++) begin
            if (c > 0) next_cycle();
            if (c == 95) rcode_h = {24'h000000, 24'h13579B};
            if (c == 96) valid_h = 2'b00;
            #2;
            if (c <= 95) begin
                checks++;
                if (ready_h !== ((c == 0 || c == 95) ? 2'b01 : 2'b00)) begin
                    failures++;
                    $display("FAIL hold_ready c=%0d got %b expected %b", c, ready_h, (c == 0 || c == 95) ? 2'b01 : 2'b00);
                end
            end
            if (c == 32 || c == 95 || c == 96) begin
                checks++;
                if (busy_h !== 1'b1 || code_h !== ((c == 96) ? 24'h13579B : 24'hABCDEF)) begin
                    failures++;
                    $display("FAIL hold_code c=%0d got busy=%b code=%h expected busy=1 code=%h", c, busy_h, code_h,
                             (c == 96) ? 24'h13579B : 24'hABCDEF);
                end
            end
        end
        checks++;
        if (sb_h.size() != 0) begin
            failures++;
            $display("FAIL hold_drain got %0d pending expected 0", sb_h.size());
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            if (c > 0) next_cycle();
            if (c == 5) begin
                valid_a = 2'b01;
                rcode_a = {24'h000000, 24'h55AA55};
            end else if (c == 6) begin
                valid_a = 2'b00;
            end
            #2;
            if (c == 6) begin
                checks++;
                if (code_a !== 24'h55AA55 || busy_a !== 1'b1) begin
                    failures++;
                    $display("FAIL abort_accept got code=%h busy=%b expected 55AA55 1", code_a, busy_a);
                end
            end
        end
        next_cycle();
        rst_n = 1'b0;
        #2;
        checks++;
        if (code_a !== 24'h0 || busy_a !== 1'b0 || done_a !== 2'b00 || ready_a !== 2'b00) begin
            failures++;
            $display("FAIL abort_reset got code=%h busy=%b done=%b ready=%b expected all 0", code_a, busy_a, done_a, ready_a);
        end
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) next_cycle();
            #2;
            checks++;
            if (tick_a !== (c == 31) || done_a !== 2'b00 || code_a !== 24'h0 || busy_a !== 1'b0) begin
                failures++;
                $display("FAIL abort_after c=%0d got tick=%b done=%b code=%h busy=%b expected tick=%b others 0",
                         c, tick_a, done_a, code_a, busy_a, (c == 31));
            end
        end
    endtask

    initial begin
        valid_a = 2'b00;
        valid_h = 2'b00;
        rcode_a = 48'h0;
        rcode_h = 48'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_tick_accept();
        test_hold_frames();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
